// File: rtl/harmonic_mixer_pkg.sv
// Shared types, widths and defaults for the harmonic mixer, plus the pan-gain
// and clamp arithmetic used by the accumulate path.
package harmonic_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam int GAIN_W            = 9;
    localparam int ACC_W             = 32;
    localparam int SAMPLE_W          = 16;
    localparam int PAN_W             = 8;
    localparam int PROD_W            = SAMPLE_W + GAIN_W + 1;
    localparam int DEF_CLOCK_DIV     = 1280;
    localparam int DEF_MAX_HARMONICS = 256;

    localparam logic signed [ACC_W-1:0] DEF_CLAMP_MAX = 32'sh0001FAFF;
    localparam logic signed [ACC_W-1:0] DEF_CLAMP_MIN = -32'sh00020500;

    // Signed sample times unsigned gain, floor-divided by 256, sign-extended.
    function automatic logic signed [ACC_W-1:0] pan_scale(
        input logic signed [SAMPLE_W-1:0] sample,
        input logic        [GAIN_W-1:0]   gain
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
        return {{(ACC_W - (PROD_W - 8)){prod[PROD_W-1]}}, prod[PROD_W-1:8]};
    endfunction

    function automatic logic signed [ACC_W-1:0] clamp(
        input logic signed [ACC_W-1:0] value,
        input logic signed [ACC_W-1:0] lo,
        input logic signed [ACC_W-1:0] hi
    );
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/harmonic_mixer_if.sv
// Harmonic word stream from the oscillator bank and the clamped L/R sample
// stream toward the DAC stage.
interface harmonic_mixer_if;
    import harmonic_mixer_pkg::*;

    logic                       i_Harm_Valid;
    logic signed [SAMPLE_W-1:0] i_Harm_Sample;
    logic        [PAN_W-1:0]    i_Harm_Pan;
    logic                       i_Harm_Last;
    logic                       o_Frame_Start;
    logic signed [ACC_W-1:0]    o_Sample_L;
    logic signed [ACC_W-1:0]    o_Sample_R;
    logic                       o_Start;
    logic                       o_Overrun;

    modport slave (
        input  i_Harm_Valid, i_Harm_Sample, i_Harm_Pan, i_Harm_Last,
        output o_Frame_Start, o_Sample_L, o_Sample_R, o_Start, o_Overrun
    );

    modport master (
        output i_Harm_Valid, i_Harm_Sample, i_Harm_Pan, i_Harm_Last,
        input  o_Frame_Start, o_Sample_L, o_Sample_R, o_Start, o_Overrun
    );

endinterface

// File: rtl/harmonic_mixer_sample_tick_gen.sv
// Free-running sample-rate divider; o_Tick is high on the wrap cycle of a
// 0..CLOCK_DIV-1 counter.
module sample_tick_gen
    import harmonic_mixer_pkg::*;
#(
    parameter int CLOCK_DIV = DEF_CLOCK_DIV
) (
    input  logic i_Clock,
    input  logic i_Reset,
    output logic o_Tick
);
    localparam int CNT_W = $clog2(CLOCK_DIV);

    logic [CNT_W-1:0] r_Count;

    assign o_Tick = (r_Count == CNT_W'(CLOCK_DIV - 1));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)
            r_Count <= '0;
        else if (o_Tick)
            r_Count <= '0;
        else
            r_Count <= r_Count + 1'b1;
    end

endmodule

// File: rtl/harmonic_mixer.sv
// Requests one harmonic frame per sample tick, pans and accumulates the words
// into L/R sums, and presents the clamped sums with a one-cycle o_Start.
module harmonic_mixer
    import harmonic_mixer_pkg::*;
#(
    parameter int                      CLOCK_DIV     = DEF_CLOCK_DIV,
    parameter int                      MAX_HARMONICS = DEF_MAX_HARMONICS,
    parameter logic signed [ACC_W-1:0] CLAMP_MAX     = DEF_CLAMP_MAX,
    parameter logic signed [ACC_W-1:0] CLAMP_MIN     = DEF_CLAMP_MIN
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    harmonic_mixer_if.slave bus
);
    state_t                  r_State, w_Next;
    logic                    w_Tick;
    logic                    r_Tick_Pending;
    logic                    r_Drain;
    logic                    r_Overrun;
    logic [GAIN_W-1:0]       r_Word_Cnt;
    logic                    w_Accept, w_Frame_End, w_Begin, w_Load_Out, w_Start;
    logic [GAIN_W-1:0]       w_Gain_L, w_Gain_R;
    logic                    r_P1_Valid;
    logic signed [ACC_W-1:0] r_P1_L, r_P1_R;
    logic signed [ACC_W-1:0] r_Acc_L, r_Acc_R;
    logic signed [ACC_W-1:0] r_Sample_L, r_Sample_R;

    sample_tick_gen #(.CLOCK_DIV(CLOCK_DIV)) u_tick (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .o_Tick  (w_Tick)
    );

    assign w_Gain_R    = {1'b0, bus.i_Harm_Pan};
    assign w_Gain_L    = GAIN_W'(256) - w_Gain_R;
    assign w_Accept    = (r_State == ST_ACCUM) && bus.i_Harm_Valid;
    // The cap word ends the frame exactly like an explicit last word.
    assign w_Frame_End = w_Accept &&
                         (bus.i_Harm_Last || (r_Word_Cnt == GAIN_W'(MAX_HARMONICS - 1)));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)
            r_State <= ST_IDLE;
        else
            r_State <= w_Next;
    end

    always_comb begin
        w_Next     = r_State;
        w_Begin    = 1'b0;
        w_Load_Out = 1'b0;
        w_Start    = 1'b0;
        case (r_State)
            ST_IDLE: begin
                if (r_Tick_Pending) begin
                    w_Begin = 1'b1;
                    w_Next  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_Frame_End)
                    w_Next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Second drain cycle: the accumulators now hold the last word.
                if (r_Drain) begin
                    w_Load_Out = 1'b1;
                    w_Next     = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_Start = 1'b1;
                w_Next  = ST_IDLE;
            end
            default: w_Next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Tick_Pending <= 1'b0;
            r_Overrun      <= 1'b0;
            r_Drain        <= 1'b0;
            r_Word_Cnt     <= '0;
        end else begin
            // A tick landing on the frame-start cycle is merged into that frame.
            if (w_Begin)
                r_Tick_Pending <= 1'b0;
            else if (w_Tick)
                r_Tick_Pending <= 1'b1;
            if (w_Tick && (r_State != ST_IDLE))
                r_Overrun <= 1'b1;
            r_Drain <= (r_State == ST_DRAIN) ? ~r_Drain : 1'b0;
            if (w_Begin)
                r_Word_Cnt <= '0;
            else if (w_Accept)
                r_Word_Cnt <= r_Word_Cnt + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_P1_Valid <= 1'b0;
            r_P1_L     <= '0;
            r_P1_R     <= '0;
            r_Acc_L    <= '0;
            r_Acc_R    <= '0;
        end else begin
            r_P1_Valid <= w_Accept;
            if (w_Accept) begin
                r_P1_L <= pan_scale(bus.i_Harm_Sample, w_Gain_L);
                r_P1_R <= pan_scale(bus.i_Harm_Sample, w_Gain_R);
            end
            if (w_Begin) begin
                r_Acc_L <= '0;
                r_Acc_R <= '0;
            end else if (r_P1_Valid) begin
                r_Acc_L <= r_Acc_L + r_P1_L;
                r_Acc_R <= r_Acc_R + r_P1_R;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sample_L <= '0;
            r_Sample_R <= '0;
        end else if (w_Load_Out) begin
            r_Sample_L <= clamp(r_Acc_L, CLAMP_MIN, CLAMP_MAX);
            r_Sample_R <= clamp(r_Acc_R, CLAMP_MIN, CLAMP_MAX);
        end
    end

    assign bus.o_Frame_Start = w_Begin;
    assign bus.o_Start       = w_Start;
    assign bus.o_Sample_L    = r_Sample_L;
    assign bus.o_Sample_R    = r_Sample_R;
    assign bus.o_Overrun     = r_Overrun;

endmodule

// File: tb/tb_harmonic_mixer.sv
// Scenario bench for harmonic_mixer: expected L/R sums and o_Start cycles are
// queued when the frame is driven and compared when o_Start appears.
module tb_harmonic_mixer;
    import harmonic_mixer_pkg::*;

    localparam int DIV = 64;

    typedef struct {
        logic signed [31:0] l;
        logic signed [31:0] r;
        int                 cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   nc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   starts1 = 0;
    int   starts2 = 0;
    exp_t exp_q[$];
    int   w_s[$];
    int   w_p[$];

    always #5 clk = ~clk;

    harmonic_mixer_if hb();
    harmonic_mixer_if hc();

    harmonic_mixer #(.CLOCK_DIV(DIV)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (hb.slave)
    );

    harmonic_mixer #(.CLOCK_DIV(DIV), .MAX_HARMONICS(4)) dut_cap (
        .i_Clock (clk),
        .i_Reset (rst2),
        .bus     (hc.slave)
    );

    always @(posedge clk) begin
        nc <= nc + 1;
        if (hb.o_Start) starts1 <= starts1 + 1;
        if (hc.o_Start) starts2 <= starts2 + 1;
    end

    function automatic logic signed [31:0] sat(input longint v);
        if (v > 64'sh1FAFF) return 32'sh1FAFF;
        if (v < -64'sh20500) return -32'sh20500;
        return 32'(v);
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got %0d want %0d", name, got, want);
        else
            n_pass++;
    endtask

    task automatic wait_frame1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (hb.o_Frame_Start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (hb.o_Start) begin ok = 1'b1; break; end
        end
    endtask

    // Drives w_s/w_p starting the negedge after the caller's; model sums queued on the last word.
    task automatic drive_frame(input bit use_last);
        longint sl = 0, sr = 0;
        exp_t   e;
        for (int i = 0; i < w_s.size(); i++) begin
            @(negedge clk);
            hb.i_Harm_Valid  = 1'b1;
            hb.i_Harm_Sample = 16'(w_s[i]);
            hb.i_Harm_Pan    = 8'(w_p[i]);
            hb.i_Harm_Last   = use_last && (i == w_s.size() - 1);
            sl += longint'((w_s[i] * (256 - w_p[i])) >>> 8);
            sr += longint'((w_s[i] * w_p[i]) >>> 8);
            if (hb.i_Harm_Last) begin
                e.l = sat(sl); e.r = sat(sr); e.cyc = nc + 3;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        hb.i_Harm_Valid = 1'b0;
        hb.i_Harm_Last  = 1'b0;
    endtask

    task automatic collect1(input string name);
        bit   ok;
        exp_t e;
        wait_start1(ok);
        n_chk++;
        if (!ok) begin
            $display("FAIL %s_start: got no o_Start want pulse", name);
            exp_q.delete();
        end else begin
            n_pass++;
            e = exp_q.pop_front();
            n_chk++;
            if (hb.o_Sample_L !== e.l)
                $display("FAIL %s_L: got %0d want %0d", name, hb.o_Sample_L, e.l);
            else n_pass++;
            n_chk++;
            if (hb.o_Sample_R !== e.r)
                $display("FAIL %s_R: got %0d want %0d", name, hb.o_Sample_R, e.r);
            else n_pass++;
            n_chk++;
            if (nc !== e.cyc)
                $display("FAIL %s_latency: got cycle %0d want %0d", name, nc, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        hb.i_Harm_Valid = 0; hb.i_Harm_Sample = 0; hb.i_Harm_Pan = 0; hb.i_Harm_Last = 0;
        hc.i_Harm_Valid = 0; hc.i_Harm_Sample = 0; hc.i_Harm_Pan = 0; hc.i_Harm_Last = 0;
        repeat (3) @(negedge clk);
        chk("reset_L", hb.o_Sample_L, 0);
        chk("reset_R", hb.o_Sample_R, 0);
        chk("reset_start", hb.o_Start, 0);
        chk("reset_frame_start", hb.o_Frame_Start, 0);
        chk("reset_overrun", hb.o_Overrun, 0);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        bit ok;
        wait_frame1(ok);
        chk("single_frame_seen", ok, 1);
        chk("single_overrun", hb.o_Overrun, 0);
        w_s = '{1000}; w_p = '{128};
        drive_frame(1'b1);
        collect1("single");
        chk("single_L_500", hb.o_Sample_L, 500);
    endtask

    task automatic test_pan_extremes();
        bit ok;
        wait_frame1(ok);
        chk("pan_frame_seen", ok, 1);
        w_s = '{-1000, 400}; w_p = '{0, 255};
        drive_frame(1'b1);
        collect1("pan");
        chk("pan_L_m999", hb.o_Sample_L, -999);
        chk("pan_R_398", hb.o_Sample_R, 398);
    endtask

    task automatic test_saturation();
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            wait_frame1(ok);
            chk("sat_frame_seen", ok, 1);
            w_s.delete(); w_p.delete();
            for (int i = 0; i < 16; i++) begin
                w_s.push_back(pass == 0 ? 32767 : -32768);
                w_p.push_back(0);
            end
            drive_frame(1'b1);
            collect1(pass == 0 ? "sat_pos" : "sat_neg");
        end
        chk("sat_neg_L", hb.o_Sample_L, -132352);
    endtask

    task automatic test_overrun();
        bit ok;
        int f0, t_last;
        exp_t e;
        wait_frame1(ok);
        chk("ovr_frame_seen", ok, 1);
        f0 = nc;
        chk("ovr_before", hb.o_Overrun, 0);
        @(negedge clk);
        hb.i_Harm_Valid = 1; hb.i_Harm_Sample = 16'sd100; hb.i_Harm_Pan = 0; hb.i_Harm_Last = 0;
        @(negedge clk);
        hb.i_Harm_Valid = 0;
        while (nc < f0 + 80) @(negedge clk);
        hb.i_Harm_Valid = 1; hb.i_Harm_Last = 1;
        t_last = nc;
        e.l = 200; e.r = 0; e.cyc = nc + 3;
        exp_q.push_back(e);
        @(negedge clk);
        hb.i_Harm_Valid = 0; hb.i_Harm_Last = 0;
        collect1("ovr");
        chk("ovr_sticky", hb.o_Overrun, 1);
        wait_frame1(ok);
        chk("ovr_restart_cycle", ok ? nc : -1, t_last + 4);
        w_s = '{7}; w_p = '{0};
        drive_frame(1'b1);
        collect1("ovr_next");
        wait_frame1(ok);
        chk("ovr_no_double", ok ? nc : -1, f0 + 2 * DIV);
        chk("ovr_still", hb.o_Overrun, 1);
    endtask

    task automatic test_cap();
        bit ok;
        int c0, want_cyc;
        @(negedge clk);
        rst2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (hc.o_Frame_Start) begin ok = 1'b1; break; end
        end
        chk("cap_frame_seen", ok, 1);
        c0 = starts2;
        want_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hc.i_Harm_Valid = 1; hc.i_Harm_Sample = 16'sd100; hc.i_Harm_Pan = 0; hc.i_Harm_Last = 0;
            if (i == 3) want_cyc = nc + 3;
        end
        @(negedge clk);
        hc.i_Harm_Valid = 0;
        while (nc < want_cyc) @(negedge clk);
        chk("cap_start", hc.o_Start, 1);
        chk("cap_L", hc.o_Sample_L, 400);
        chk("cap_R", hc.o_Sample_R, 0);
        repeat (10) @(negedge clk);
        chk("cap_single_start", starts2 - c0, 1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c0, r0;
        @(negedge clk);
        hb.i_Harm_Valid = 1; hb.i_Harm_Sample = 16'sd500; hb.i_Harm_Pan = 0; hb.i_Harm_Last = 0;
        @(negedge clk);
        hb.i_Harm_Valid = 0;
        c0 = starts1;
        #2 rst = 1'b1;
        #1;
        chk("rmid_L", hb.o_Sample_L, 0);
        chk("rmid_R", hb.o_Sample_R, 0);
        chk("rmid_overrun", hb.o_Overrun, 0);
        chk("rmid_start", hb.o_Start, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r0 = nc;
        repeat (10) @(negedge clk);
        chk("rmid_no_start", starts1 - c0, 0);
        wait_frame1(ok);
        chk("rmid_frame_cycle", ok ? nc : -1, r0 + DIV);
        w_s = '{-300}; w_p = '{64};
        drive_frame(1'b1);
        collect1("rmid_clean");
        chk("rmid_clean_L", hb.o_Sample_L, -225);
        chk("rmid_clean_R", hb.o_Sample_R, -75);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_pan_extremes();
        test_saturation();
        test_overrun();
        test_cap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
